// File: rtl/cache_ctrl_sa_pkg.sv
// Shared types and width helpers for the set-associative cache controller.
// Build option: CACHE_CTRL_STATS_EN adds hit/miss/write-back counters on the top.
package cache_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITEBACK,
    S_REFILL,
    S_RESPOND
  } state_t;

  typedef struct packed {
    logic valid;
    logic dirty;
  } line_meta_t;

  localparam int CNT_W = 16;

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int sets);
    return addr_w - $clog2(sets);
  endfunction

  // Way select needs at least one bit even for a direct-mapped build.
  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cache_ctrl_sa_if.sv
// Requester and backing-memory signals of cache_ctrl_sa.
// Requester: i_start is a one-cycle strobe taken only while idle; o_done pulses once per request.
// Memory: o_mem_req/o_mem_wr/o_mem_addr/o_mem_wdata hold steady until the single-cycle i_mem_ack.
interface cache_ctrl_sa_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  logic              i_start;
  logic              i_wr;
  logic [ADDR_W-1:0] i_address;
  logic [DATA_W-1:0] i_wdata;
  logic [DATA_W-1:0] o_rdata;
  logic              o_done;
  logic              o_hit;
  logic              o_busy;
  logic              o_mem_req;
  logic              o_mem_wr;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [DATA_W-1:0] i_mem_rdata;
  logic              i_mem_ack;

  modport master (
    output i_start, i_wr, i_address, i_wdata, i_mem_rdata, i_mem_ack,
    input  o_rdata, o_done, o_hit, o_busy, o_mem_req, o_mem_wr, o_mem_addr, o_mem_wdata
  );

  modport slave (
    input  i_start, i_wr, i_address, i_wdata, i_mem_rdata, i_mem_ack,
    output o_rdata, o_done, o_hit, o_busy, o_mem_req, o_mem_wr, o_mem_addr, o_mem_wdata
  );
endinterface

// File: rtl/cache_ctrl_sa_way.sv
// One cache way: per-set valid/dirty/tag/data with a combinational index read
// and a single write port that always leaves the written line valid.
module cache_way
  import cache_ctrl_pkg::*;
#(
  parameter int SETS   = 8,
  parameter int IDX_W  = 3,
  parameter int TAG_W  = 7,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic              rd_valid,
  output logic              rd_dirty,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [DATA_W-1:0] rd_data,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic              wr_dirty,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [DATA_W-1:0] wr_data
);

  line_meta_t        meta [SETS];
  logic [TAG_W-1:0]  tags [SETS];
  logic [DATA_W-1:0] data [SETS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) meta[s] <= '0;
    end else if (we) begin
      meta[wr_idx] <= '{valid: 1'b1, dirty: wr_dirty};
    end
  end

  // Tag/data need no reset: they are only observed through a valid line.
  always_ff @(posedge clk) begin
    if (we) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = meta[rd_idx].valid;
  assign rd_dirty = meta[rd_idx].dirty;
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_idx];

endmodule

// File: rtl/cache_ctrl_sa.sv
// Set-associative write-back/write-allocate cache controller with per-set round-robin
// replacement. Build option: CACHE_CTRL_STATS_EN adds o_hit_cnt/o_miss_cnt/o_wb_cnt.
module cache_ctrl_sa
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32,
  parameter int SETS   = 8,
  parameter int WAYS   = 2
) (
  input  logic           i_clk,
  input  logic           i_rst,
  cache_ctrl_sa_if.slave bus,
  output state_t         o_state
`ifdef CACHE_CTRL_STATS_EN
  ,
  output logic [CNT_W-1:0] o_hit_cnt,
  output logic [CNT_W-1:0] o_miss_cnt,
  output logic [CNT_W-1:0] o_wb_cnt
`endif
);

  localparam int IDX_W = idx_w(SETS);
  localparam int TAG_W = tag_w(ADDR_W, SETS);
  localparam int WAY_W = way_w(WAYS);

  state_t            state;
  logic [ADDR_W-1:0] req_addr;
  logic              req_wr;
  logic [DATA_W-1:0] req_wdata;
  logic [WAY_W-1:0]  sel_way;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  assign req_idx = req_addr[IDX_W-1:0];
  assign req_tag = req_addr[ADDR_W-1:IDX_W];

  logic [WAYS-1:0]   way_valid;
  logic [WAYS-1:0]   way_dirty;
  logic [WAYS-1:0]   way_we;
  logic [TAG_W-1:0]  way_tag  [WAYS];
  logic [DATA_W-1:0] way_data [WAYS];
  logic [WAY_W-1:0]  rr_ptr   [SETS];

  logic              hit_any;
  logic [WAY_W-1:0]  hit_idx;
  logic              inv_any;
  logic [WAY_W-1:0]  inv_idx;
  logic [WAY_W-1:0]  victim;
  logic              victim_dirty;
  logic              fill_we;
  logic              resp_we;
  logic [DATA_W-1:0] wr_data;

  always_comb begin
    hit_any = 1'b0;
    hit_idx = '0;
    inv_any = 1'b0;
    inv_idx = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (way_valid[w] && (way_tag[w] == req_tag) && !hit_any) begin
        hit_any = 1'b1;
        hit_idx = WAY_W'(w);
      end
      if (!way_valid[w] && !inv_any) begin
        inv_any = 1'b1;
        inv_idx = WAY_W'(w);
      end
    end
  end

  assign victim       = inv_any ? inv_idx : rr_ptr[req_idx];
  assign victim_dirty = way_valid[victim] & way_dirty[victim];

  // Lines are written in two places: the refill ack and the RESPOND cycle of a write.
  assign fill_we = (state == S_REFILL) && bus.i_mem_ack;
  assign resp_we = (state == S_RESPOND) && req_wr;
  assign wr_data = resp_we ? req_wdata : bus.i_mem_rdata;

  always_comb begin
    way_we = '0;
    for (int w = 0; w < WAYS; w++) begin
      way_we[w] = (fill_we || resp_we) && (sel_way == WAY_W'(w));
    end
  end

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    cache_way #(
      .SETS  (SETS),
      .IDX_W (IDX_W),
      .TAG_W (TAG_W),
      .DATA_W(DATA_W)
    ) u_way (
      .clk     (i_clk),
      .rst     (i_rst),
      .rd_idx  (req_idx),
      .rd_valid(way_valid[g]),
      .rd_dirty(way_dirty[g]),
      .rd_tag  (way_tag[g]),
      .rd_data (way_data[g]),
      .we      (way_we[g]),
      .wr_idx  (req_idx),
      .wr_dirty(resp_we),
      .wr_tag  (req_tag),
      .wr_data (wr_data)
    );
  end

  // The pointer only moves when it actually picked the victim (all ways valid).
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int s = 0; s < SETS; s++) rr_ptr[s] <= '0;
    end else if ((WAYS > 1) && (state == S_LOOKUP) && !hit_any && !inv_any) begin
      rr_ptr[req_idx] <= rr_ptr[req_idx] + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state           <= S_IDLE;
      req_addr        <= '0;
      req_wr          <= 1'b0;
      req_wdata       <= '0;
      sel_way         <= '0;
      bus.o_rdata     <= '0;
      bus.o_done      <= 1'b0;
      bus.o_hit       <= 1'b0;
      bus.o_busy      <= 1'b0;
      bus.o_mem_req   <= 1'b0;
      bus.o_mem_wr    <= 1'b0;
      bus.o_mem_addr  <= '0;
      bus.o_mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.i_start) begin
            req_addr   <= bus.i_address;
            req_wr     <= bus.i_wr;
            req_wdata  <= bus.i_wdata;
            bus.o_busy <= 1'b1;
            state      <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (hit_any) begin
            sel_way    <= hit_idx;
            bus.o_hit  <= 1'b1;
            bus.o_done <= 1'b1;
            if (!req_wr) bus.o_rdata <= way_data[hit_idx];
            state <= S_RESPOND;
          end else begin
            sel_way <= victim;
            if (victim_dirty) begin
              bus.o_mem_req   <= 1'b1;
              bus.o_mem_wr    <= 1'b1;
              bus.o_mem_addr  <= {way_tag[victim], req_idx};
              bus.o_mem_wdata <= way_data[victim];
              state           <= S_WRITEBACK;
            end else if (!req_wr) begin
              bus.o_mem_req  <= 1'b1;
              bus.o_mem_wr   <= 1'b0;
              bus.o_mem_addr <= req_addr;
              state          <= S_REFILL;
            end else begin
              bus.o_done <= 1'b1;
              state      <= S_RESPOND;
            end
          end
        end
        S_WRITEBACK: begin
          if (bus.i_mem_ack) begin
            bus.o_mem_wr <= 1'b0;
            if (req_wr) begin
              bus.o_mem_req <= 1'b0;
              bus.o_done    <= 1'b1;
              state         <= S_RESPOND;
            end else begin
              bus.o_mem_addr <= req_addr;
              state          <= S_REFILL;
            end
          end
        end
        S_REFILL: begin
          if (bus.i_mem_ack) begin
            bus.o_mem_req <= 1'b0;
            bus.o_rdata   <= bus.i_mem_rdata;
            bus.o_done    <= 1'b1;
            state         <= S_RESPOND;
          end
        end
        S_RESPOND: begin
          bus.o_done <= 1'b0;
          bus.o_hit  <= 1'b0;
          bus.o_busy <= 1'b0;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_state = state;

`ifdef CACHE_CTRL_STATS_EN
  logic [CNT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;
  logic [CNT_W-1:0] wb_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      wb_cnt   <= '0;
    end else if (state == S_LOOKUP) begin
      if (hit_any) begin
        hit_cnt <= sat_inc(hit_cnt);
      end else begin
        miss_cnt <= sat_inc(miss_cnt);
        if (victim_dirty) wb_cnt <= sat_inc(wb_cnt);
      end
    end
  end

  assign o_hit_cnt  = hit_cnt;
  assign o_miss_cnt = miss_cnt;
  assign o_wb_cnt   = wb_cnt;
`endif

endmodule

// File: doc/cache_ctrl_sa.md
# cache_ctrl_sa

Parametrised set-associative, write-back, write-allocate cache controller; successor to the fixed direct-mapped read-only controller. Sits between a single requester (start/wr/address handshake) and a backing memory with a req/ack handshake. Supports reads and writes, configurable sets/ways/widths, dirty-line write-back, per-set round-robin replacement.

## Interface
- ADDR_W, 10, request address width (word addresses)
- DATA_W, 32, data word width; one word per line
- SETS, 8, number of sets, power of two, ≥2
- WAYS, 2, associativity, power of two, ≥1
- i_clk  in  1  clock
- i_rst  in  1  reset; one clock; reset is synchronous and active-high
- i_start  in  1  request strobe, sampled only in IDLE
- i_wr  in  1  1 = write, 0 = read; sampled with i_start
- i_address  in  ADDR_W  request address
- i_wdata  in  DATA_W  write data
- o_rdata  out  DATA_W  read data, valid while o_done
- o_done  out  1  one-cycle completion pulse
- o_hit  out  1  lookup result of current request, valid while o_done
- o_busy  out  1  high from accept until o_done cycle inclusive
- o_mem_req, o_mem_wr  out  1  memory request, 1 = write-back
- o_mem_addr  out  ADDR_W; o_mem_wdata  out  DATA_W
- i_mem_rdata  in  DATA_W; i_mem_ack  in  1  one-cycle acknowledge, rdata valid with it

## Operation
- Address split: index = i_address[log2(SETS)-1:0], tag = remaining upper bits (TAG_W = ADDR_W − log2(SETS)).
- Per way/set: valid, dirty, tag, data. Per set: round-robin pointer, log2(WAYS) bits (absent when WAYS=1).
- FSM: IDLE → LOOKUP on i_start (address, wr, wdata latched). LOOKUP: hit → RESPOND; miss with victim dirty → WRITEBACK; miss clean → read: REFILL, write: RESPOND (allocate, no refill).
- WRITEBACK: o_mem_req=1, o_mem_wr=1, o_mem_addr={victim tag, index}, o_mem_wdata=victim data; on ack → REFILL (read) or RESPOND (write).
- REFILL: o_mem_req=1, o_mem_wr=0, o_mem_addr=latched address; on ack install line valid, clean, data=i_mem_rdata → RESPOND.
- RESPOND: o_done=1 one cycle, → IDLE. Read: o_rdata = line data. Write: line data=wdata, dirty=1, valid=1.
- Victim: lowest-index invalid way; if none, way at RR pointer. Pointer advances (mod WAYS) on every allocation using it; hits do not move it.
- i_start outside IDLE ignored; not queued.
- o_mem_req, o_mem_wr, o_mem_addr, o_mem_wdata stable until the ack cycle.

## Timing
- Reset: all valid/dirty/pointers cleared; state IDLE; o_done, o_hit, o_busy, o_mem_req, o_mem_wr = 0; o_rdata, o_mem_addr, o_mem_wdata = 0.
- Reset mid-operation: request abandoned, o_mem_req drops next edge, no o_done; a late i_mem_ack in IDLE ignored.
- Hit latency: i_start at edge N → o_done high cycle after edge N+2 (LOOKUP, RESPOND).
- Miss latency: 2 + cycles to each ack; ack in first REQ cycle gives 3 (clean read miss) or 4 (dirty read miss).
- Write miss on clean/invalid victim: same latency as hit, o_hit=0.
- i_start in the o_done cycle ignored; next accept earliest the following cycle.

## Configuration
- CACHE_CTRL_STATS_EN defined: adds outputs o_hit_cnt, o_miss_cnt, o_wb_cnt (16-bit, saturating at 0xFFFF, cleared by reset), incremented in the LOOKUP cycle (wb on entering WRITEBACK). Undefined: ports and counters absent, behaviour otherwise identical.

## Structure
- Package cache_ctrl_pkg: state enum (IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND), line struct type helpers, TAG_W/IDX_W computation functions, counter width constant.
- Sub-module cache_way: one way's valid/dirty/tag/data arrays with index read and single-port write, instantiated WAYS times via generate; controller holds FSM, hit compare, victim select, RR pointers.

## Test plan
- Reset, read 25 (mem returns 0xA5) → miss, one REFILL at addr 25, o_rdata=0xA5, o_hit=0; read 25 again → o_hit=1, o_done 2 cycles after accept, no o_mem_req.
- Read 25, 30 (index 1, 6) then 25 → both resident, third access hits.
- Write 25=0x11, write 33=0x22 (same set, 2 ways), read 41 → writeback addr 25 data 0x11, then refill 41; read 25 → miss.
- Write miss to invalid set → no memory traffic, o_hit=0; following read returns written data.
- Delay i_mem_ack 5 cycles → mem outputs stable, i_start pulses ignored, o_busy held.
- Assert i_rst during REFILL → o_mem_req low next cycle, no o_done, all lines invalid afterwards; with CACHE_CTRL_STATS_EN, counters zero.
